// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operand request handshake plus result handshake.
// Member names are seen from the ALU side, so the ALU uses the slave modport.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             ovf_o;

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    input  ready_o, valid_o, data_o, zero_o, ovf_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    output ready_o, valid_o, data_o, zero_o, ovf_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/slt, optional WIDTH-step shift-add multiply.
// Define MULTICYCLE_ALU_MUL_EN to build the multiplier; otherwise opcode 2 returns 0 in one cycle.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  multicycle_alu_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpOr  = 3'd4;
  localparam logic [2:0] OpXor = 3'd5;
  localparam logic [2:0] OpSlt = 3'd6;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign op_a = bus.data1_i;
  assign op_b = bus.data2_i;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Single-cycle result, evaluated straight from the request inputs at acceptance.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.ALUCtrl_i)
      OpAdd: begin
        res     = sum;
        res_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpSub: begin
        res     = diff;
        res_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpMul: res = '0;
      OpAnd: res = op_a & op_b;
      OpOr:  res = op_a | op_b;
      OpXor: res = op_a ^ op_b;
      OpSlt: res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: res = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic             last_step;

  // Bits shifted past the top of mcand drop out, giving the product mod 2^WIDTH.
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
`ifdef MULTICYCLE_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
`ifdef MULTICYCLE_ALU_MUL_EN
          if (bus.ALUCtrl_i == OpMul) begin
            state_d  = StBusy;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = StDone;
            data_d  = res;
            zero_d  = (res == '0);
            ovf_d   = res_ovf;
          end
`else
          state_d = StDone;
          data_d  = res;
          zero_d  = (res == '0);
          ovf_d   = res_ovf;
`endif
        end
      end
      StBusy: begin
`ifdef MULTICYCLE_ALU_MUL_EN
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (last_step) begin
          state_d = StDone;
          data_d  = acc_step;
          zero_d  = (acc_step == '0);
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (bus.ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULTICYCLE_ALU_MUL_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`endif

  assign bus.ready_o = (state_q == StIdle);
  assign bus.valid_o = (state_q == StDone);
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
  assign bus.ovf_o   = ovf_q;
endmodule
